// File: rtl/dds_phase_acc.sv
// dds_phase_acc -- DDS phase accumulator with shadowed tuning word.
//
// A frequency tuning word (FTW) arrives from a UART receiver as a one-cycle
// strobe. It is clipped to FTW_MAX (Nyquist) and then either applied at once
// or held in a shadow register until the next phase wrap. Holding it keeps
// frequency changes phase-continuous at a cycle boundary.
//
// Parameters:
//   ACC_W    accumulator / tuning-word width
//   ADDR_W   waveform-LUT address width (top ADDR_W accumulator bits)
//   FTW_MAX  largest tuning word that will be applied
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   ftw_in          incoming tuning word
//   ftw_valid       one-cycle strobe qualifying ftw_in
//   sync_mode       1 = apply new word at next wrap, 0 = apply immediately
//   enable          1 = accumulate, 0 = hold phase
//   phase_clr       synchronous accumulator clear (phase-aligned restart)
//   phase_addr      waveform-LUT address (combinational from acc)
//   phase_wrap      registered one-cycle carry-out strobe
//   ftw_active      tuning word currently being accumulated
//   update_pending  a shadow word is waiting for a wrap
//   ftw_clipped     sticky flag: a captured word exceeded FTW_MAX
//
// Build option:
//   DDS_PHASE_DITHER_EN  adds a 16-bit LFSR whose low byte dithers the
//                        LUT address just below its LSB.

module dds_phase_acc #(
    parameter int               ACC_W   = 32,
    parameter int               ADDR_W  = 12,
    parameter logic [ACC_W-1:0] FTW_MAX = ACC_W'(32'h7FFF_FFFF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ACC_W-1:0]  ftw_in,
    input  logic              ftw_valid,
    input  logic              sync_mode,
    input  logic              enable,
    input  logic              phase_clr,
    output logic [ADDR_W-1:0] phase_addr,
    output logic              phase_wrap,
    output logic [ACC_W-1:0]  ftw_active,
    output logic              update_pending,
    output logic              ftw_clipped
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   shadow_q, shadow_d;
    logic [ACC_W-1:0]   ftw_active_q, ftw_active_d;
    logic               phase_wrap_q, phase_wrap_d;
    logic               ftw_clipped_q, ftw_clipped_d;

    logic               over_max;
    logic [ACC_W-1:0]   ftw_clip;
    logic [ACC_W:0]     acc_sum;
    logic               carry;

    // Nyquist clip of the incoming word.
    always_comb begin
        over_max = (ftw_in > FTW_MAX);
        ftw_clip = over_max ? FTW_MAX : ftw_in;
    end

    // Accumulator. The carry only exists on a real add, so a clear or a
    // hold cycle can never produce a wrap.
    always_comb begin
        acc_sum      = {1'b0, acc_q} + {1'b0, ftw_active_q};
        acc_d        = acc_q;
        carry        = 1'b0;
        if (phase_clr) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_sum[ACC_W-1:0];
            carry = acc_sum[ACC_W];
        end
        phase_wrap_d = carry;
    end

    // Word-update state machine. Any valid word is captured into the shadow.
    // In PEND, a wrap, a clear or a drop to immediate mode applies the
    // pending word; a word arriving on that same cycle wins over the old
    // shadow.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        ftw_active_d  = ftw_active_q;
        ftw_clipped_d = ftw_clipped_q;

        if (ftw_valid) begin
            shadow_d = ftw_clip;
            if (over_max) begin
                ftw_clipped_d = 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (ftw_valid) begin
                    if (phase_clr || !sync_mode) begin
                        ftw_active_d = ftw_clip;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (phase_clr || carry || !sync_mode) begin
                    ftw_active_d = ftw_valid ? ftw_clip : shadow_q;
                    state_d      = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            acc_q         <= '0;
            shadow_q      <= '0;
            ftw_active_q  <= '0;
            phase_wrap_q  <= 1'b0;
            ftw_clipped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            shadow_q      <= shadow_d;
            ftw_active_q  <= ftw_active_d;
            phase_wrap_q  <= phase_wrap_d;
            ftw_clipped_q <= ftw_clipped_d;
        end
    end

`ifdef DDS_PHASE_DITHER_EN
    localparam int DITH_SHIFT = ACC_W - ADDR_W - 8;

    logic [15:0]      lfsr_q, lfsr_d;
    logic [ACC_W-1:0] dith_sum;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // The LFSR byte sits just under the address LSB, so it only nudges
    // the address by at most one step.
    always_comb begin
        dith_sum   = acc_q + (ACC_W'(lfsr_q[7:0]) << DITH_SHIFT);
        phase_addr = dith_sum[ACC_W-1 -: ADDR_W];
    end
`else
    assign phase_addr = acc_q[ACC_W-1 -: ADDR_W];
`endif

    assign phase_wrap     = phase_wrap_q;
    assign ftw_active     = ftw_active_q;
    assign update_pending = (state_q == ST_PEND);
    assign ftw_clipped    = ftw_clipped_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// tb_dds_phase_acc -- bench for dds_phase_acc.
//
// A behavioural model tracks phase, active word, pending word and the
// sticky clip flag as plain integers. One process compares every output
// against that model each cycle. Directed sequences add hand-computed
// literal expectations. Inputs change on the falling edge; outputs are
// sampled away from the rising edge.

module tb_dds_phase_acc;

    localparam int          ACC_W   = 32;
    localparam int          ADDR_W  = 12;
    localparam logic [31:0] FTW_MAX = 32'h7FFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [31:0] ftw_in;
    logic        ftw_valid;
    logic        sync_mode;
    logic        enable;
    logic        phase_clr;
    logic [11:0] phase_addr;
    logic        phase_wrap;
    logic [31:0] ftw_active;
    logic        update_pending;
    logic        ftw_clipped;

    int checks   = 0;
    int failures = 0;
    int print_budget = 40;

    dds_phase_acc #(
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W),
        .FTW_MAX(FTW_MAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ftw_in        (ftw_in),
        .ftw_valid     (ftw_valid),
        .sync_mode     (sync_mode),
        .enable        (enable),
        .phase_clr     (phase_clr),
        .phase_addr    (phase_addr),
        .phase_wrap    (phase_wrap),
        .ftw_active    (ftw_active),
        .update_pending(update_pending),
        .ftw_clipped   (ftw_clipped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    logic [31:0] m_acc;
    logic [31:0] m_active;
    logic [31:0] m_shadow;
    logic        m_pending;
    logic        m_wrap;
    logic        m_clipped;
    logic [15:0] m_lfsr;
    logic        model_ready = 1'b0;
    logic [32:0] m_sum;
    logic        m_carry;
    logic [31:0] m_word;
    logic [31:0] m_dith;
    logic [11:0] m_addr;

    // Model update: what the next state must be given this cycle's inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_acc     = 32'd0;
            m_active  = 32'd0;
            m_shadow  = 32'd0;
            m_pending = 1'b0;
            m_wrap    = 1'b0;
            m_clipped = 1'b0;
            m_lfsr    = 16'hACE1;
        end else begin
            m_word  = (ftw_in > FTW_MAX) ? FTW_MAX : ftw_in;
            m_carry = 1'b0;
            if (phase_clr) begin
                m_acc = 32'd0;
            end else if (enable) begin
                m_sum   = {1'b0, m_acc} + {1'b0, m_active};
                m_carry = m_sum[32];
                m_acc   = m_sum[31:0];
            end
            if (ftw_valid && ftw_in > FTW_MAX) m_clipped = 1'b1;
            if (ftw_valid) begin
                if (phase_clr || !sync_mode || (m_pending && m_carry)) begin
                    m_active  = m_word;
                    m_pending = 1'b0;
                end else begin
                    m_shadow  = m_word;
                    m_pending = 1'b1;
                end
            end else if (m_pending && (phase_clr || m_carry || !sync_mode)) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            m_wrap = m_carry;
            if (enable) begin
                m_lfsr = (m_lfsr >> 1) |
                         (16'((m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5])) << 15);
            end
        end
        model_ready = 1'b1;
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #2;
        if (model_ready) begin
`ifdef DDS_PHASE_DITHER_EN
            m_dith = m_acc + (32'(m_lfsr[7:0]) << 12);
            m_addr = m_dith[31:20];
`else
            m_addr = m_acc[31:20];
`endif
            checks += 5;
            if (phase_addr !== m_addr) begin
                failures++;
                if (print_budget > 0) begin
                    print_budget--;
                    $display("[TB] FAIL model_phase_addr t=%0t got=%h want=%h", $time, phase_addr, m_addr);
                end
            end
            if (ftw_active !== m_active) begin
                failures++;
                if (print_budget > 0) begin
                    print_budget--;
                    $display("[TB] FAIL model_ftw_active t=%0t got=%h want=%h", $time, ftw_active, m_active);
                end
            end
            if (update_pending !== m_pending) begin
                failures++;
                if (print_budget > 0) begin
                    print_budget--;
                    $display("[TB] FAIL model_update_pending t=%0t got=%b want=%b", $time, update_pending, m_pending);
                end
            end
            if (phase_wrap !== m_wrap) begin
                failures++;
                if (print_budget > 0) begin
                    print_budget--;
                    $display("[TB] FAIL model_phase_wrap t=%0t got=%b want=%b", $time, phase_wrap, m_wrap);
                end
            end
            if (ftw_clipped !== m_clipped) begin
                failures++;
                if (print_budget > 0) begin
                    print_budget--;
                    $display("[TB] FAIL model_ftw_clipped t=%0t got=%b want=%b", $time, ftw_clipped, m_clipped);
                end
            end
        end
    end

    // Drive one cycle of inputs and wait until the edge has taken them.
    task automatic applyStimulus(input logic valid, input logic [31:0] word,
                                 input logic sync, input logic en, input logic clr);
        ftw_valid = valid;
        ftw_in    = word;
        sync_mode = sync;
        enable    = en;
        phase_clr = clr;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%h want=%h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    int          bad;
    int          wraps;
    int          first_wrap;
    int          second_wrap;
    int          waited;
    logic [11:0] prev_addr;
    bit          seen;
`ifdef DDS_PHASE_DITHER_EN
    int          ones;
    int          zeros;
`endif

    initial begin
        rst_n     = 1'b0;
        ftw_in    = 32'd0;
        ftw_valid = 1'b0;
        sync_mode = 1'b0;
        enable    = 1'b0;
        phase_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state.
        checkOutput("reset_phase_addr", 32'(phase_addr), 32'd0);
        checkOutput("reset_ftw_active", ftw_active, 32'd0);
        checkOutput("reset_pending", 32'(update_pending), 32'd0);
        checkOutput("reset_wrap", 32'(phase_wrap), 32'd0);
        checkOutput("reset_clipped", 32'(ftw_clipped), 32'd0);
        rst_n = 1'b1;

        // Immediate update: step of 16 addresses, wrap every 256 cycles.
        applyStimulus(1'b1, 32'h0100_0000, 1'b0, 1'b1, 1'b0);
        checkOutput("imm_ftw_active", ftw_active, 32'h0100_0000);
        checkOutput("imm_addr0", 32'(phase_addr), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("imm_addr1", 32'(phase_addr), 32'd16);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("imm_addr2", 32'(phase_addr), 32'd32);
        bad = 0; wraps = 0; first_wrap = 0; second_wrap = 0;
        prev_addr = phase_addr;
        for (int i = 1; i <= 600; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            if (12'(phase_addr - prev_addr) != 12'd16) bad++;
            prev_addr = phase_addr;
            if (phase_wrap) begin
                wraps++;
                if (wraps == 1) first_wrap = i;
                if (wraps == 2) second_wrap = i;
            end
        end
        checkOutput("imm_step_errors", 32'(bad), 32'd0);
        checkOutput("imm_wrap_count", 32'(wraps), 32'd2);
        checkOutput("imm_wrap_period", 32'(second_wrap - first_wrap), 32'd256);

        // Synchronised update: new word only at the carry edge.
        doReset();
        applyStimulus(1'b1, 32'h1000_0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h2000_0000, 1'b1, 1'b1, 1'b0);
        checkOutput("sync_pending_set", 32'(update_pending), 32'd1);
        checkOutput("sync_active_held", ftw_active, 32'h1000_0000);
        bad = 0; waited = 0; seen = 1'b0;
        for (int i = 1; i <= 32 && !seen; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            if (phase_wrap) begin
                seen   = 1'b1;
                waited = i;
            end else if (!update_pending || ftw_active != 32'h1000_0000) begin
                bad++;
            end
        end
        checkOutput("sync_wrap_seen", 32'(seen), 32'd1);
        checkOutput("sync_wait_cycles", 32'(waited), 32'd12);
        checkOutput("sync_early_change", 32'(bad), 32'd0);
        checkOutput("sync_pending_clear", 32'(update_pending), 32'd0);
        checkOutput("sync_active_new", ftw_active, 32'h2000_0000);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("sync_addr_after", 32'(phase_addr), 32'd512);

        // Clipping and the sticky flag.
        doReset();
        applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        checkOutput("clip_edge_active", ftw_active, 32'h7FFF_FFFF);
        checkOutput("clip_edge_flag", 32'(ftw_clipped), 32'd0);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        checkOutput("clip_active", ftw_active, 32'h7FFF_FFFF);
        checkOutput("clip_flag", 32'(ftw_clipped), 32'd1);
        applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b0);
        checkOutput("clip_inrange_active", ftw_active, 32'h0000_1000);
        checkOutput("clip_sticky", 32'(ftw_clipped), 32'd1);
        doReset();
        checkOutput("clip_reset_clear", 32'(ftw_clipped), 32'd0);

        // Overwrite on the exact wrap cycle applies the newest word.
        applyStimulus(1'b1, 32'h4000_0000, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0800_0000, 1'b1, 1'b1, 1'b0);
        checkOutput("ovr_pending", 32'(update_pending), 32'd1);
        checkOutput("ovr_active_old", ftw_active, 32'h4000_0000);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("ovr_addr_pre", 32'(phase_addr), 32'hC00);
        applyStimulus(1'b1, 32'h0000_0010, 1'b1, 1'b1, 1'b0);
        checkOutput("ovr_active_new", ftw_active, 32'h0000_0010);
        checkOutput("ovr_wrap", 32'(phase_wrap), 32'd1);
        checkOutput("ovr_pending_clear", 32'(update_pending), 32'd0);

        // Clear together with a new word in sync mode.
        doReset();
        applyStimulus(1'b1, 32'h0100_0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("clr_addr_pre", 32'(phase_addr), 32'd80);
        applyStimulus(1'b1, 32'h0400_0000, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_addr_zero", 32'(phase_addr), 32'd0);
        checkOutput("clr_active", ftw_active, 32'h0400_0000);
        checkOutput("clr_pending", 32'(update_pending), 32'd0);
        checkOutput("clr_wrap", 32'(phase_wrap), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("clr_addr_next", 32'(phase_addr), 32'd64);

        // Hold for 100 cycles.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            if (phase_addr != 12'd64 || phase_wrap) bad++;
        end
        checkOutput("hold_errors", 32'(bad), 32'd0);

        // Reset while a word is pending discards it.
        applyStimulus(1'b1, 32'h3000_0000, 1'b1, 1'b1, 1'b0);
        checkOutput("rstp_pending", 32'(update_pending), 32'd1);
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h5000_0000, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        checkOutput("rstp_addr", 32'(phase_addr), 32'd0);
        checkOutput("rstp_active", ftw_active, 32'd0);
        checkOutput("rstp_pending_clear", 32'(update_pending), 32'd0);
        checkOutput("rstp_wrap", 32'(phase_wrap), 32'd0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            if (ftw_active != 32'd0 || phase_addr != 12'd0 || update_pending || phase_wrap) bad++;
        end
        checkOutput("rstp_never_applied", 32'(bad), 32'd0);

`ifdef DDS_PHASE_DITHER_EN
        // Dither: with the phase parked just under an address step, the
        // LFSR byte toggles only the address LSB.
        doReset();
        applyStimulus(1'b1, 32'h000F_F000, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
        bad = 0; ones = 0; zeros = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            if (phase_addr[11:1] != 11'd0) bad++;
            if (phase_addr[0]) ones++; else zeros++;
        end
        checkOutput("dith_upper_bits", 32'(bad), 32'd0);
        checkOutput("dith_lsb_one", 32'(ones > 0), 32'd1);
        checkOutput("dith_lsb_zero", 32'(zeros > 0), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
